// File: rtl/instr_loader.sv
// Byte-stream program loader: assembles 21-bit opcodes from 3-byte groups and writes them to
// the instruction store. Optional XOR trailer check enabled by defining LOADER_CSUM_EN.
module instr_loader #(
    parameter int unsigned NUM_ENTRIES = 10,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [20:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] prog_len
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LEN  = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] CSUM = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        bsel_q, bsel_d;
    logic [4:0]        hi_q, hi_d;
    logic [7:0]        mid_q, mid_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [20:0]       wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] prog_len_q, prog_len_d;
`ifdef LOADER_CSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif
    logic              xfer;

    assign in_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign busy     = in_ready;
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign prog_len = prog_len_q;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        bsel_d     = bsel_q;
        hi_d       = hi_q;
        mid_d      = mid_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        prog_len_d = prog_len_q;
`ifdef LOADER_CSUM_EN
        xor_d      = xor_q;
`endif
        if (state_q == DONE) begin
            prog_len_d = len_q;
        end
        // A restart wins over any byte presented in the same cycle.
        if (load_start) begin
            state_d = LEN;
            idx_d   = '0;
            bsel_d  = '0;
`ifdef LOADER_CSUM_EN
            xor_d   = '0;
`endif
        end else begin
            case (state_q)
                LEN: begin
                    if (xfer) begin
`ifdef LOADER_CSUM_EN
                        xor_d = xor_q ^ in_data;
`endif
                        if (in_data == 8'd0 || 32'(in_data) > NUM_ENTRIES) begin
                            state_d = ERR;
                        end else begin
                            len_d   = in_data[ADDR_W-1:0];
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
`ifdef LOADER_CSUM_EN
                        xor_d = xor_q ^ in_data;
`endif
                        case (bsel_q)
                            2'd0: begin
                                if (in_data[7:5] != 3'b000) begin
                                    state_d = ERR;
                                end else begin
                                    hi_d   = in_data[4:0];
                                    bsel_d = 2'd1;
                                end
                            end
                            2'd1: begin
                                mid_d  = in_data;
                                bsel_d = 2'd2;
                            end
                            default: begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = idx_q;
                                wr_data_d = {hi_q, mid_q, in_data};
                                bsel_d    = 2'd0;
                                idx_d     = idx_q + ADDR_W'(1);
                                if (idx_q == len_q - ADDR_W'(1)) begin
`ifdef LOADER_CSUM_EN
                                    state_d = CSUM;
`else
                                    state_d = DONE;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef LOADER_CSUM_EN
                CSUM: begin
                    if (xfer) begin
                        state_d = (in_data == xor_q) ? DONE : ERR;
                    end
                end
`endif
                DONE:    state_d = IDLE;
                IDLE:    state_d = IDLE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            bsel_q     <= '0;
            hi_q       <= '0;
            mid_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            prog_len_q <= '0;
`ifdef LOADER_CSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            bsel_q     <= bsel_d;
            hi_q       <= hi_d;
            mid_q      <= mid_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            prog_len_q <= prog_len_d;
`ifdef LOADER_CSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader; adapts trailer handling to LOADER_CSUM_EN.
module tb_instr_loader;
    localparam int unsigned NE = 10;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready, wr_en, busy, done, err;
    logic [AW-1:0] wr_addr, prog_len;
    logic [20:0]   wr_data;

    instr_loader #(.NUM_ENTRIES(NE), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .err(err), .prog_len(prog_len)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] wa [0:127];
    logic [20:0]   wd [0:127];
    int            wn = 0;
    int            dn = 0;
    logic [7:0]    acc = 8'h00;
    int            b;
    int            d;
    logic [7:0]    s5 [0:9] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h07,
                                8'h1F, 8'hFF, 8'hFF};

    // Write/done log, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (wr_en && wn < 128) begin
            wa[wn] = wr_addr;
            wd[wn] = wr_data;
            wn++;
        end
        if (done) dn++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v);
        int k = 0;
        in_data  = v;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: in_ready got 0 want 1");
        end
        acc ^= v;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        in_valid   = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        acc        = 8'h00;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Sends the XOR trailer (good or corrupted) only when the checksum feature is built in.
    task automatic trailer(input bit good);
`ifdef LOADER_CSUM_EN
        send(good ? acc : (acc ^ 8'h01));
`else
        if (!good) $display("note: trailer skipped, checksum disabled");
`endif
    endtask

    task automatic send_prog1();
        send(8'h02);
        send(8'h01); send(8'h23); send(8'h45);
        send(8'h00); send(8'h00); send(8'h07);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_prog_len", prog_len, 0);
        reset = 1'b0;
        @(negedge clk);

        // Happy path
        pulse_start();
        check("t1_busy_len", busy, 1);
        b = wn;
        send_prog1();
        check("t1_last_wr_en", wr_en, 1);
`ifdef LOADER_CSUM_EN
        check("t1_done_wait_csum", done, 0);
        trailer(1'b1);
        check("t1_done", done, 1);
`else
        check("t1_done_with_write", done, 1);
`endif
        idle(1);
        check("t1_nwrites", wn - b, 2);
        check("t1_a0", wa[b], 0);
        check("t1_d0", wd[b], 21'h012345);
        check("t1_a1", wa[b+1], 1);
        check("t1_d1", wd[b+1], 21'h000007);
        check("t1_prog_len", prog_len, 2);
        check("t1_busy", busy, 0);
        check("t1_err", err, 0);

`ifdef LOADER_CSUM_EN
        // Wrong trailer
        pulse_start();
        d = dn;
        send_prog1();
        trailer(1'b0);
        idle(1);
        check("t2_err", err, 1);
        check("t2_no_done", dn - d, 0);
        check("t2_prog_len", prog_len, 2);
`endif

        // Length bounds
        pulse_start();
        b = wn;
        send(8'h00);
        idle(1);
        check("t3_len0_err", err, 1);
        check("t3_len0_nowr", wn - b, 0);
        check("t3_err_not_ready", in_ready, 0);
        pulse_start();
        check("t3_err_cleared", err, 0);
        send(8'h0B);
        idle(1);
        check("t3_len11_err", err, 1);
        pulse_start();
        b = wn;
        send(8'h0A);
        for (int i = 0; i < 10; i++) begin
            send(8'(i)); send(8'(i * 3)); send(8'(i + 1));
        end
        trailer(1'b1);
        idle(1);
        check("t3_nwrites", wn - b, 10);
        for (int i = 0; i < 10; i++) begin
            check("t3_addr", wa[b+i], i);
            check("t3_data", wd[b+i], {5'(i), 8'(i * 3), 8'(i + 1)});
        end
        check("t3_prog_len", prog_len, 10);

        // Bad opcode header byte
        pulse_start();
        b = wn;
        send(8'h01);
        send(8'h20);
        idle(1);
        check("t4_err", err, 1);
        check("t4_nowr", wn - b, 0);
        pulse_start();
        check("t4_err_clear", err, 0);
        check("t4_busy", busy, 1);
        check("t4_ready", in_ready, 1);

        // Stalls between every byte (already in LEN)
        b = wn;
        for (int i = 0; i < 10; i++) begin
            send(s5[i]);
            if (i < 9) begin
                in_valid = 1'b0;
                @(negedge clk);
                check("t5_ready_stall", in_ready, 1);
            end
        end
        trailer(1'b1);
        idle(1);
        check("t5_nwrites", wn - b, 3);
        check("t5_d0", wd[b], 21'h012345);
        check("t5_d1", wd[b+1], 21'h000007);
        check("t5_d2", wd[b+2], 21'h1FFFFF);
        check("t5_a2", wa[b+2], 2);
        check("t5_prog_len", prog_len, 3);

        // Abort mid-opcode, then a fresh one-opcode load
        pulse_start();
        b = wn;
        send(8'h02);
        send(8'h01); send(8'h23); send(8'h45);
        send(8'h00); send(8'h00);
        pulse_start();
        send(8'h01);
        send(8'h00); send(8'h00); send(8'h2A);
        trailer(1'b1);
        idle(1);
        check("t6_nwrites", wn - b, 2);
        check("t6_a_new", wa[b+1], 0);
        check("t6_d_new", wd[b+1], 21'h00002A);
        check("t6_prog_len", prog_len, 1);

        // Reset mid-load
        pulse_start();
        b = wn;
        send(8'h02);
        send(8'h00); send(8'h00); send(8'h07);
        reset = 1'b1;
        @(negedge clk);
        check("t6r_wr_en", wr_en, 0);
        check("t6r_wr_addr", wr_addr, 0);
        check("t6r_wr_data", wr_data, 0);
        check("t6r_ready", in_ready, 0);
        check("t6r_busy", busy, 0);
        check("t6r_done", done, 0);
        check("t6r_err", err, 0);
        check("t6r_prog_len", prog_len, 0);
        reset = 1'b0;
        idle(3);
        check("t6r_nwrites", wn - b, 1);
        check("t6r_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
